// File: rtl/ssd_accumulator.sv
// Sum-of-squared-differences accumulator.
// Consumes a stream of signed products from the square/diff multiplier and
// produces one saturating SSD result per in_last-delimited vector, together
// with its beat count and a sticky overflow flag, on a valid/ready port.
module ssd_accumulator #(
  parameter int IN_W  = 34,
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Saturating signed add; MSB of the result flags that a clamp happened.
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W:0] full;
    full = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (full[ACC_W] != full[ACC_W-1]) begin
      sat_add = full[ACC_W] ? {1'b1, ACC_MIN} : {1'b1, ACC_MAX};
    end else begin
      sat_add = {1'b0, full[ACC_W-1:0]};
    end
  endfunction

  // Beat counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     ovf_q, ovf_d;
  logic signed [ACC_W-1:0]  out_sum_q, out_sum_d;
  logic [CNT_W-1:0]         out_count_q, out_count_d;
  logic                     out_overflow_q, out_overflow_d;
  logic                     out_valid_q, out_valid_d;
  logic                     in_ready_q, in_ready_d;

  logic signed [ACC_W-1:0]  in_ext;
  logic signed [ACC_W-1:0]  add_sum;
  logic                     add_clamp;
  logic                     accept;

  assign in_ext               = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign {add_clamp, add_sum} = sat_add(acc_q, in_ext);
  assign accept               = in_valid && in_ready_q;

  assign in_ready     = in_ready_q;
  assign out_sum      = out_sum_q;
  assign out_count    = out_count_q;
  assign out_overflow = out_overflow_q;
  assign out_valid    = out_valid_q;

  // Next-state: accumulate accepted beats, publish on in_last, wait for handshake.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    ovf_d          = ovf_q;
    out_sum_d      = out_sum_q;
    out_count_d    = out_count_q;
    out_overflow_d = out_overflow_q;
    out_valid_d    = out_valid_q;
    if (state_q == ACCUM) begin
      if (accept) begin
        if (in_last) begin
          out_sum_d      = add_sum;
          out_count_d    = sat_inc(cnt_q);
          out_overflow_d = ovf_q | add_clamp;
          out_valid_d    = 1'b1;
          state_d        = HOLD;
          acc_d          = '0;
          cnt_d          = '0;
          ovf_d          = 1'b0;
        end else begin
          acc_d = add_sum;
          cnt_d = sat_inc(cnt_q);
          ovf_d = ovf_q | add_clamp;
        end
      end
    end else if (out_valid_q && out_ready) begin
      // Result fields keep their last values after the handshake.
      out_valid_d = 1'b0;
      state_d     = ACCUM;
    end
    // in_ready is a pure function of the registered state: no path from out_ready.
    in_ready_d = (state_d == ACCUM);
  end

  // State and result registers; reset discards any partial vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ACCUM;
      acc_q          <= '0;
      cnt_q          <= '0;
      ovf_q          <= 1'b0;
      out_sum_q      <= '0;
      out_count_q    <= '0;
      out_overflow_q <= 1'b0;
      out_valid_q    <= 1'b0;
      in_ready_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      ovf_q          <= ovf_d;
      out_sum_q      <= out_sum_d;
      out_count_q    <= out_count_d;
      out_overflow_q <= out_overflow_d;
      out_valid_q    <= out_valid_d;
      in_ready_q     <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_ssd_accumulator.sv
// Testbench for ssd_accumulator. Two instances share one input stream:
// 'a' uses the default widths, 'b' uses ACC_W=36 / CNT_W=3 so that sum
// saturation and count saturation are reachable in a short run.
module tb_ssd_accumulator;

  localparam int IN_W  = 34;
  localparam int ACC_A = 48;
  localparam int CNT_A = 16;
  localparam int ACC_B = 36;
  localparam int CNT_B = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             out_ready = 1'b1;

  logic             in_ready_a, in_ready_b;
  logic [ACC_A-1:0] out_sum_a;
  logic [ACC_B-1:0] out_sum_b;
  logic [CNT_A-1:0] out_count_a;
  logic [CNT_B-1:0] out_count_b;
  logic             out_overflow_a, out_overflow_b;
  logic             out_valid_a, out_valid_b;

  always #5 clk = ~clk;

  ssd_accumulator #(.IN_W(IN_W), .ACC_W(ACC_A), .CNT_W(CNT_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready_a), .out_sum(out_sum_a),
    .out_count(out_count_a), .out_overflow(out_overflow_a),
    .out_valid(out_valid_a), .out_ready(out_ready)
  );

  ssd_accumulator #(.IN_W(IN_W), .ACC_W(ACC_B), .CNT_W(CNT_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready_b), .out_sum(out_sum_b),
    .out_count(out_count_b), .out_overflow(out_overflow_b),
    .out_valid(out_valid_b), .out_ready(out_ready)
  );

  typedef struct {
    longint data;
    bit     last;
    int     gap;
    longint sum_a;
    int     cnt_a;
    bit     ovf_a;
    longint sum_b;
    int     cnt_b;
    bit     ovf_b;
  } beat_t;

  typedef struct {
    longint sum_a;
    int     cnt_a;
    bit     ovf_a;
    longint sum_b;
    int     cnt_b;
    bit     ovf_b;
  } exp_t;

  beat_t tbl[$];
  exp_t  sb_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic beat_t mk(longint d, bit l, int g, longint sa, int ca,
                               bit oa, longint sb, int cb, bit ob);
    beat_t r;
    r.data = d;  r.last = l;  r.gap = g;
    r.sum_a = sa; r.cnt_a = ca; r.ovf_a = oa;
    r.sum_b = sb; r.cnt_b = cb; r.ovf_b = ob;
    return r;
  endfunction

  task automatic push_exp(longint sa, int ca, bit oa, longint sb, int cb, bit ob);
    exp_t e;
    e.sum_a = sa; e.cnt_a = ca; e.ovf_a = oa;
    e.sum_b = sb; e.cnt_b = cb; e.ovf_b = ob;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until a clock edge sees in_ready high.
  task automatic send(input longint d, input bit last);
    bit done;
    done     = 1'b0;
    in_data  = d[IN_W-1:0];
    in_valid = 1'b1;
    in_last  = last;
    for (int t = 0; t < 40 && !done; t++) begin
      if (in_ready_a) done = 1'b1;
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed %0b for data %0d", in_ready_a, d);
    end
  endtask

  // Idle cycles with in_last asserted and junk data, which must be ignored.
  task automatic bubble(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_last  = 1'b1;
      in_data  = {2'b10, 32'($urandom())};
      step();
    end
    in_last = 1'b0;
  endtask

  // Scoreboard: every result handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && (out_valid_a || out_valid_b) && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got sum %0d with no result expected",
                 $signed(out_sum_a));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("res_valid_a", out_valid_a, 1);
        check("res_valid_b", out_valid_b, 1);
        check("res_sum_a", $signed(out_sum_a), e.sum_a);
        check("res_count_a", out_count_a, e.cnt_a);
        check("res_ovf_a", out_overflow_a, e.ovf_a);
        check("res_sum_b", $signed(out_sum_b), e.sum_b);
        check("res_count_b", out_count_b, e.cnt_b);
        check("res_ovf_b", out_overflow_b, e.ovf_b);
      end
    end
  end

  initial begin
    longint big, neg;
    big = 64'd8589934591;
    neg = -64'sd8589934592;

    // Four-beat vector with two bubbles before the third beat.
    tbl.push_back(mk(9,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(16, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(25, 0, 2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(36, 1, 0, 86, 4, 0, 86, 4, 0));
    // Single-beat vector of the largest positive product.
    tbl.push_back(mk(big, 1, 1, big, 1, 0, big, 1, 0));
    // Five maximal beats: saturates only in the 36-bit accumulator.
    for (int i = 0; i < 4; i++) tbl.push_back(mk(big, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(big, 1, 0, 64'd42949672955, 5, 0, 64'd34359738367, 5, 1));
    // Accumulator and overflow flag start clean on the next vector.
    tbl.push_back(mk(5, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5, 1, 0, 10, 2, 0, 10, 2, 0));
    // Negative saturation in the 36-bit accumulator.
    for (int i = 0; i < 4; i++) tbl.push_back(mk(neg, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(-1, 1, 0, -64'sd34359738369, 5, 0, -64'sd34359738368, 5, 1));
    // Nine beats: the 3-bit counter sticks at 7.
    for (int i = 1; i < 9; i++) tbl.push_back(mk(i, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(9, 1, 0, 45, 9, 0, 45, 7, 0));

    // Asynchronous reset asserted mid-cycle.
    #3 rst_n = 1'b0;
    #1;
    check("rst_sum_a", out_sum_a, 0);
    check("rst_count_a", out_count_a, 0);
    check("rst_ovf_a", out_overflow_a, 0);
    check("rst_valid_a", out_valid_a, 0);
    check("rst_ready_a", in_ready_a, 0);
    check("rst_valid_b", out_valid_b, 0);
    check("rst_ready_b", in_ready_b, 0);
    step();
    step();
    check("rst_hold_ready_a", in_ready_a, 0);
    rst_n = 1'b1;
    step();
    check("rel_ready_a", in_ready_a, 1);
    check("rel_ready_b", in_ready_b, 1);
    check("rel_valid_a", out_valid_a, 0);

    // Table-driven vectors with out_ready held high.
    for (int i = 0; i < tbl.size(); i++) begin
      bubble(tbl[i].gap);
      if (tbl[i].last)
        push_exp(tbl[i].sum_a, tbl[i].cnt_a, tbl[i].ovf_a,
                 tbl[i].sum_b, tbl[i].cnt_b, tbl[i].ovf_b);
      send(tbl[i].data, tbl[i].last);
      if (tbl[i].last) begin
        check("pub_valid_a", out_valid_a, 1);
        check("pub_ready_a", in_ready_a, 0);
        step();
        check("ack_valid_a", out_valid_a, 0);
        check("ack_ready_a", in_ready_a, 1);
      end
    end

    // Backpressure: result held and new beats refused while out_ready is low.
    out_ready = 1'b0;
    send(1, 0);
    send(2, 0);
    push_exp(6, 3, 0, 6, 3, 0);
    send(3, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 34'd100;
      in_last  = 1'b0;
      check("bp_valid_a", out_valid_a, 1);
      check("bp_sum_a", $signed(out_sum_a), 6);
      check("bp_count_a", out_count_a, 3);
      check("bp_ready_a", in_ready_a, 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_rel_ready_a", in_ready_a, 1);
    check("bp_rel_valid_a", out_valid_a, 0);
    check("bp_keep_sum_a", $signed(out_sum_a), 6);
    push_exp(4, 1, 0, 4, 1, 0);
    send(4, 1);
    step();

    // Reset in the middle of a vector drops the partial sum.
    send(7, 0);
    send(8, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid_a", out_valid_a, 0);
    check("mid_rst_ready_a", in_ready_a, 0);
    step();
    rst_n = 1'b1;
    step();
    check("mid_rel_ready_a", in_ready_a, 1);
    push_exp(3, 2, 0, 3, 2, 0);
    send(1, 0);
    send(2, 1);
    step();

    for (int t = 0; t < 20 && sb_q.size() != 0; t++) step();
    check("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd_accumulator.md
Name: ssd_accumulator

Overview:
- Downstream consumer of the pipelined squared-difference DSP stage.
- Accumulates a stream of signed squared-difference products into one sum-of-squared-differences (SSD) result per vector. Vectors are delimited by in_last.
- Presents each result with its beat count and an overflow flag on a valid/ready output port.
- Sits between the square/diff multiplier and the distance/compare logic.

Parameters:
- IN_W, 34, width of incoming signed product (matches 2*SIZEIN+2 of the multiplier for SIZEIN=16).
- ACC_W, 48, accumulator and result width. Must satisfy ACC_W >= IN_W+1.
- CNT_W, 16, beat-counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  IN_W  signed product from the multiplier.
- in_valid  in  1  in_data is valid this cycle.
- in_last  in  1  qualifies the final beat of a vector; meaningful only with in_valid.
- in_ready  out  1  block accepts a beat this cycle.
- out_sum  out  ACC_W  signed SSD result.
- out_count  out  CNT_W  number of beats in the vector, including the last.
- out_overflow  out  1  accumulation saturated during this vector.
- out_valid  out  1  result held on the out_* ports.
- out_ready  in  1  downstream accepts the result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=ACCUM, acc=0, cnt=0, ovf=0.
  - out_sum=0, out_count=0, out_overflow=0, out_valid=0.
  - in_ready forced 0 while rst_n is low; in_ready=1 in the first cycle after release.
  - Reset mid-vector discards the partial vector entirely; no partial result is emitted.
- Two-state FSM: ACCUM and HOLD.
- in_ready is 1 exactly when state=ACCUM (registered state only; no combinational path from out_ready).
- Accept condition: in_valid && in_ready. Cycles with in_valid=0 are bubbles and change nothing.
- Accepted beat, in_last=0:
  - acc <= sat_add(acc, sext(in_data)).
  - cnt <= cnt+1, saturating at all-ones.
  - ovf <= ovf | (sat_add clamped).
- Accepted beat, in_last=1:
  - out_sum <= sat_add(acc, sext(in_data)); out_count <= cnt+1 (saturating).
  - out_overflow <= ovf | (clamped this beat).
  - out_valid <= 1, state <= HOLD; acc, cnt, ovf cleared to 0.
  - Latency: result visible on the cycle after the last beat is accepted.
- sat_add:
  - ACC_W-bit signed addition.
  - On positive overflow, clamp to 2^(ACC_W-1)-1; on negative overflow, clamp to -2^(ACC_W-1).
  - Further beats after clamping continue to add saturating from the clamped value.
- HOLD state:
  - in_ready=0; beats presented are not consumed and have no effect.
  - out_* held stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid <= 0, state <= ACCUM. in_ready returns to 1 on the next cycle. out_sum, out_count and out_overflow retain their last values.
- in_last with in_valid=0 is ignored.
- in_data is treated as signed. Squares are non-negative in normal use, but negative inputs must accumulate correctly.

Test Plan:
1. Reset and release:
   - Assert rst_n=0 asynchronously mid-cycle.
   - All outputs go 0 immediately; in_ready=0 during reset, then 1 one cycle after release.
2. Four-beat vector, out_ready=1:
   - Beats 9, 16, 25, 36, with two bubble cycles between beats 2 and 3; in_last on 36.
   - Next cycle: out_sum=86, out_count=4, out_overflow=0, out_valid=1 for exactly one cycle.
   - in_ready=1 again the following cycle.
3. Backpressure:
   - Complete vector {1,2,3}, then hold out_ready=0 for 5 cycles while driving in_valid=1 with data 100.
   - out_valid stays 1, out_sum=6 stable, in_ready=0, the 100s are not consumed.
   - Raise out_ready: handshake completes; next vector {4} gives out_sum=4, out_count=1.
4. Single-beat vector:
   - in_data=2^33-1 with in_last on the first beat.
   - out_sum=8589934591, out_count=1, out_overflow=0.
5. Saturation (ACC_W=36 override):
   - Five beats of 8589934591, last on beat 5.
   - out_sum=34359738367, out_overflow=1.
   - Next vector {5,5} gives out_sum=10, out_overflow=0.
   - Also: ACC_W=36, vector {-2^33, -2^33, -2^33, -2^33, -1} gives out_sum=-34359738368, out_overflow=1.
6. Reset mid-vector:
   - Accept 7 and 8, then pulse rst_n low.
   - No out_valid is produced.
   - After release, vector {1,2} gives out_sum=3, out_count=2.
